// File: rtl/irq_ctl_pkg.sv
// Shared definitions for the interrupt controller: FSM state codes and
// the priority-window helper used for nested in-service arbitration.
package irq_ctl_pkg;

  localparam int MAX_CHAN = 8;

  typedef enum logic [0:0] {
    IRQ_IDLE = 1'b0,
    IRQ_ACK  = 1'b1
  } irq_state_e;

  // Channels allowed to preempt: every index strictly below the active one,
  // or all channels when nothing is in service.
  function automatic logic [MAX_CHAN-1:0] preempt_window(input logic any, input logic [2:0] idx);
    logic [MAX_CHAN-1:0] win;
    win = any ? MAX_CHAN'((32'd1 << idx) - 32'd1) : {MAX_CHAN{1'b1}};
    return win;
  endfunction

endpackage

// File: rtl/irq_ctl_if.sv
// Device/CPU-side signal bundle of the interrupt controller.
interface irq_ctl_if #(
  parameter int NCHAN = 8,
  parameter int VEC_W = 3
);
  logic [NCHAN-1:0] nreq;
  logic             mask_we;
  logic [NCHAN-1:0] mask_d;
  logic             nack;
  logic             eoi;
  logic             nirq;
  logic [VEC_W-1:0] vector;
  logic             vector_valid;
  logic             spurious;
  logic [NCHAN-1:0] pending;
  logic [NCHAN-1:0] in_service;

  modport master (
    output nreq, mask_we, mask_d, nack, eoi,
    input  nirq, vector, vector_valid, spurious, pending, in_service
  );

  modport slave (
    input  nreq, mask_we, mask_d, nack, eoi,
    output nirq, vector, vector_valid, spurious, pending, in_service
  );
endinterface

// File: rtl/irq_ctl_prio_enc.sv
// Combinational lowest-index-wins priority encoder.
module irq_ctl_prio_enc #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req_i,
  output logic         any_o,
  output logic [W-1:0] idx_o
);

  // scan from the top so the lowest set index is written last
  always_comb begin
    any_o = |req_i;
    idx_o = {W{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      idx_o = req_i[i] ? W'(i) : idx_o;
    end
  end

endmodule

// File: rtl/irq_ctl.sv
// Interrupt controller: falling-edge request latching, mask, fixed priority with
// nesting, active-low nirq/nack handshake and in-service tracking.
module irq_ctl
  import irq_ctl_pkg::*;
#(
  parameter int NCHAN = 8,
  parameter int VEC_W = 3
) (
  input logic      clock_i,
  input logic      reset_i,
  irq_ctl_if.slave bus
);

  irq_state_e       state_q, state_d;
  logic [NCHAN-1:0] nreq_q, pending_q, pending_d, in_service_q, in_service_d;
  logic [NCHAN-1:0] mask_q, mask_d;
  logic             nack_q, nirq_q, nirq_d;
  logic [VEC_W-1:0] vector_q, vector_d;
  logic             vector_valid_q, vector_valid_d, spurious_q, spurious_d;

  logic [NCHAN-1:0]    eligible_s, pend_clr_s, isv_set_s, isv_clr_s, window_s;
  logic [MAX_CHAN-1:0] window_wide_s;
  logic                win_any_s, isv_any_s, ack_fire_s;
  logic [VEC_W-1:0]    win_idx_s, isv_idx_s;

  irq_ctl_prio_enc #(.N(NCHAN), .W(VEC_W)) u_isv_enc (
    .req_i (in_service_q),
    .any_o (isv_any_s),
    .idx_o (isv_idx_s)
  );

  irq_ctl_prio_enc #(.N(NCHAN), .W(VEC_W)) u_win_enc (
    .req_i (eligible_s),
    .any_o (win_any_s),
    .idx_o (win_idx_s)
  );

  // eligibility uses the registered mask, so a write in the ack cycle is not yet seen
  always_comb begin
    window_wide_s = preempt_window(isv_any_s, 3'(isv_idx_s));
    window_s      = window_wide_s[NCHAN-1:0];
    eligible_s    = pending_q & ~mask_q & window_s;
    ack_fire_s    = (state_q == IRQ_IDLE) & nack_q & ~bus.nack & ~nirq_q;
  end

  // state register
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IRQ_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IRQ_IDLE: state_d = ack_fire_s ? IRQ_ACK : IRQ_IDLE;
      IRQ_ACK:  state_d = bus.nack ? IRQ_IDLE : IRQ_ACK;
      default:  state_d = IRQ_IDLE;
    endcase
  end

  // output and bookkeeping next-state
  always_comb begin
    nirq_d         = nirq_q;
    vector_d       = vector_q;
    vector_valid_d = vector_valid_q;
    spurious_d     = spurious_q;
    pend_clr_s     = {NCHAN{1'b0}};
    isv_set_s      = {NCHAN{1'b0}};
    case (state_q)
      IRQ_IDLE: begin
        if (ack_fire_s) begin
          nirq_d         = 1'b1;
          vector_valid_d = 1'b1;
          if (win_any_s) begin
            vector_d   = win_idx_s;
            spurious_d = 1'b0;
            pend_clr_s = {{(NCHAN-1){1'b0}}, 1'b1} << win_idx_s;
            isv_set_s  = {{(NCHAN-1){1'b0}}, 1'b1} << win_idx_s;
          end else begin
            vector_d   = {VEC_W{1'b1}};
            spurious_d = 1'b1;
          end
        end else begin
          nirq_d = ~win_any_s;
        end
      end
      IRQ_ACK: begin
        nirq_d         = 1'b1;
        vector_valid_d = bus.nack ? 1'b0 : vector_valid_q;
      end
      default: nirq_d = 1'b1;
    endcase

    isv_clr_s    = (bus.eoi & isv_any_s) ? ({{(NCHAN-1){1'b0}}, 1'b1} << isv_idx_s)
                                         : {NCHAN{1'b0}};
    // a new edge on the channel being acknowledged keeps it pending
    pending_d    = (pending_q & ~pend_clr_s) | (nreq_q & ~bus.nreq);
    in_service_d = (in_service_q & ~isv_clr_s) | isv_set_s;
    mask_d       = bus.mask_we ? bus.mask_d : mask_q;
  end

  // datapath registers
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      nreq_q         <= {NCHAN{1'b1}};
      pending_q      <= {NCHAN{1'b0}};
      in_service_q   <= {NCHAN{1'b0}};
      mask_q         <= {NCHAN{1'b1}};
      nack_q         <= 1'b1;
      nirq_q         <= 1'b1;
      vector_q       <= {VEC_W{1'b0}};
      vector_valid_q <= 1'b0;
      spurious_q     <= 1'b0;
    end else begin
      nreq_q         <= bus.nreq;
      pending_q      <= pending_d;
      in_service_q   <= in_service_d;
      mask_q         <= mask_d;
      nack_q         <= bus.nack;
      nirq_q         <= nirq_d;
      vector_q       <= vector_d;
      vector_valid_q <= vector_valid_d;
      spurious_q     <= spurious_d;
    end
  end

  assign bus.nirq         = nirq_q;
  assign bus.vector       = vector_q;
  assign bus.vector_valid = vector_valid_q;
  assign bus.spurious     = spurious_q;
  assign bus.pending      = pending_q;
  assign bus.in_service   = in_service_q;

endmodule

// File: tb/tb_irq_ctl.sv
// Bench for irq_ctl: directed scenarios with literal expectations plus a random
// phase, all outputs compared every cycle against a behavioural model.
module tb_irq_ctl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  irq_ctl_if #(.NCHAN(8), .VEC_W(3)) ifc ();

  irq_ctl #(.NCHAN(8), .VEC_W(3)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (ifc.slave)
  );

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: one update per clock from the rules of the controller
  logic [7:0] m_nreq_q, m_pend, m_isv, m_mask;
  logic [2:0] m_vec;
  bit         m_nirq, m_vv, m_sp, m_nack_q, m_in_ack;
  int         m_s, m_w;
  bit         m_fire;

  always @(posedge clk) begin
    if (rst) begin
      m_nreq_q = 8'hFF; m_pend = 8'h00; m_isv = 8'h00; m_mask = 8'hFF;
      m_vec = 3'd0; m_nirq = 1'b1; m_vv = 1'b0; m_sp = 1'b0;
      m_nack_q = 1'b1; m_in_ack = 1'b0;
    end else begin
      m_s = 8;
      for (int i = 7; i >= 0; i--) if (m_isv[i]) m_s = i;
      m_w = -1;
      for (int i = m_s - 1; i >= 0; i--) if (m_pend[i] && !m_mask[i]) m_w = i;
      m_fire = !m_in_ack && m_nack_q && !ifc.nack && !m_nirq;
      if (ifc.eoi && m_s < 8) m_isv[m_s] = 1'b0;
      if (m_fire) begin
        m_in_ack = 1'b1; m_nirq = 1'b1; m_vv = 1'b1;
        if (m_w >= 0) begin
          m_vec = 3'(m_w); m_sp = 1'b0; m_pend[m_w] = 1'b0; m_isv[m_w] = 1'b1;
        end else begin
          m_vec = 3'd7; m_sp = 1'b1;
        end
      end else if (m_in_ack) begin
        m_nirq = 1'b1;
        if (ifc.nack) begin
          m_in_ack = 1'b0; m_vv = 1'b0;
        end
      end else begin
        m_nirq = (m_w < 0);
      end
      for (int i = 0; i < 8; i++) if (m_nreq_q[i] && !ifc.nreq[i]) m_pend[i] = 1'b1;
      if (ifc.mask_we) m_mask = ifc.mask_d;
      m_nreq_q = ifc.nreq;
      m_nack_q = ifc.nack;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("nirq", 32'(ifc.nirq), 32'(m_nirq));
      chk("vector", 32'(ifc.vector), 32'(m_vec));
      chk("vector_valid", 32'(ifc.vector_valid), 32'(m_vv));
      chk("spurious", 32'(ifc.spurious), 32'(m_sp));
      chk("pending", 32'(ifc.pending), 32'(m_pend));
      chk("in_service", 32'(ifc.in_service), 32'(m_isv));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifc.nreq = 8'hFF; ifc.mask_we = 1'b0; ifc.mask_d = 8'h00;
    ifc.nack = 1'b1; ifc.eoi = 1'b0;
    tick(); tick();
    chk_en = 1'b1;
    rst = 1'b0;
  endtask

  task automatic set_mask(input logic [7:0] m);
    ifc.mask_we = 1'b1; ifc.mask_d = m;
    tick();
    ifc.mask_we = 1'b0;
  endtask

  task automatic pulse_req(input logic [7:0] chans);
    ifc.nreq = ~chans;
    tick();
    ifc.nreq = 8'hFF;
  endtask

  task automatic wait_nirq();
    int k = 0;
    while (ifc.nirq !== 1'b0 && k < 20) begin
      tick();
      k++;
    end
    chk("nirq_wait", 32'(ifc.nirq), 32'd0);
  endtask

  task automatic ack_lo();
    ifc.nack = 1'b0;
    tick();
  endtask

  task automatic ack_hi();
    ifc.nack = 1'b1;
    tick();
  endtask

  task automatic do_eoi();
    ifc.eoi = 1'b1;
    tick();
    ifc.eoi = 1'b0;
  endtask

  initial begin
    ifc.nreq = 8'hFF; ifc.mask_we = 1'b0; ifc.mask_d = 8'h00;
    ifc.nack = 1'b1; ifc.eoi = 1'b0;
    tick();

    // 1: basic request and acknowledge
    do_reset();
    chk("rst_nirq", 32'(ifc.nirq), 32'd1);
    chk("rst_pending", 32'(ifc.pending), 32'h00);
    set_mask(8'h00);
    ifc.nreq = 8'hF7;
    tick();
    ifc.nreq = 8'hFF;
    chk("t1_pend", 32'(ifc.pending), 32'h08);
    chk("t1_nirq_pre", 32'(ifc.nirq), 32'd1);
    tick();
    chk("t1_nirq", 32'(ifc.nirq), 32'd0);
    ack_lo();
    chk("t1_vec", 32'(ifc.vector), 32'd3);
    chk("t1_vv", 32'(ifc.vector_valid), 32'd1);
    chk("t1_pend0", 32'(ifc.pending), 32'h00);
    chk("t1_isv", 32'(ifc.in_service), 32'h08);
    chk("t1_nirq1", 32'(ifc.nirq), 32'd1);
    ack_hi();
    chk("t1_vv0", 32'(ifc.vector_valid), 32'd0);
    do_eoi();
    chk("t1_isv0", 32'(ifc.in_service), 32'h00);

    // 2: simultaneous requests resolve by index
    pulse_req(8'h24);
    wait_nirq();
    ack_lo();
    chk("t2_vec_a", 32'(ifc.vector), 32'd2);
    ack_hi();
    do_eoi();
    wait_nirq();
    ack_lo();
    chk("t2_vec_b", 32'(ifc.vector), 32'd5);
    ack_hi();
    do_eoi();
    chk("t2_isv0", 32'(ifc.in_service), 32'h00);

    // 3: nesting behind an active channel
    pulse_req(8'h10);
    wait_nirq();
    ack_lo();
    ack_hi();
    chk("t3_isv4", 32'(ifc.in_service), 32'h10);
    pulse_req(8'h40);
    tick(); tick();
    chk("t3_blocked", 32'(ifc.nirq), 32'd1);
    chk("t3_pend6", 32'(ifc.pending), 32'h40);
    pulse_req(8'h02);
    wait_nirq();
    ack_lo();
    chk("t3_vec1", 32'(ifc.vector), 32'd1);
    chk("t3_isv", 32'(ifc.in_service), 32'h12);
    ack_hi();
    do_eoi();
    chk("t3_eoi", 32'(ifc.in_service), 32'h10);
    do_eoi();
    wait_nirq();
    ack_lo();
    chk("t3_vec6", 32'(ifc.vector), 32'd6);
    ack_hi();
    do_eoi();

    // 4: request masked after nirq asserted gives a spurious vector
    pulse_req(8'h01);
    wait_nirq();
    set_mask(8'h01);
    ack_lo();
    chk("t4_vec", 32'(ifc.vector), 32'd7);
    chk("t4_spur", 32'(ifc.spurious), 32'd1);
    chk("t4_pend", 32'(ifc.pending), 32'h01);
    chk("t4_isv", 32'(ifc.in_service), 32'h00);
    ack_hi();
    set_mask(8'h00);
    wait_nirq();
    ack_lo();
    chk("t4_vec0", 32'(ifc.vector), 32'd0);
    chk("t4_spur0", 32'(ifc.spurious), 32'd0);
    ack_hi();
    do_eoi();

    // 5: held-low line triggers once
    ifc.nreq = 8'h7F;
    tick();
    wait_nirq();
    ack_lo();
    chk("t5_vec", 32'(ifc.vector), 32'd7);
    ack_hi();
    for (int i = 0; i < 15; i++) tick();
    chk("t5_pend", 32'(ifc.pending), 32'h00);
    chk("t5_nirq", 32'(ifc.nirq), 32'd1);
    ifc.nreq = 8'hFF;
    do_eoi();

    // 6: reset while acknowledging
    pulse_req(8'h04);
    wait_nirq();
    ack_lo();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_nirq", 32'(ifc.nirq), 32'd1);
    chk("t6_vec", 32'(ifc.vector), 32'd0);
    chk("t6_vv", 32'(ifc.vector_valid), 32'd0);
    chk("t6_pend", 32'(ifc.pending), 32'h00);
    chk("t6_isv", 32'(ifc.in_service), 32'h00);
    tick(); tick();
    ifc.nack = 1'b1;
    tick(); tick(); tick();
    chk("t6_noack_vv", 32'(ifc.vector_valid), 32'd0);
    chk("t6_noack_isv", 32'(ifc.in_service), 32'h00);

    // random phase
    set_mask(8'(($urandom_range(0, 3) == 0) ? $urandom : 0));
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 7) == 0) ifc.nreq[b] = ~ifc.nreq[b];
      end
      ifc.mask_we = ($urandom_range(0, 15) == 0);
      ifc.mask_d  = 8'($urandom) & 8'($urandom);
      ifc.eoi     = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) ifc.nack = ~ifc.nack;
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
